or3_sweep_ctrl: RTL and testbench

//  Self-checking sequencer for the 3-input OR gate datapath. Drives the gate's inputs

---
 rtl/or3_sweep_ctrl_if.sv | 37 +++
 rtl/or3_sweep_ctrl.sv | 158 +++++++++++++++
 tb/tb_or3_sweep_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/or3_sweep_ctrl_if.sv
// Signal bundle between the OR-gate sweep controller and the gate under test.
// The first_err_* signals exist only when SWEEP_ERR_LOG_EN is defined.
interface or3_sweep_ctrl_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            abort;
    logic [N_IN-1:0] dut_in;
    logic            dut_out;
    logic [N_IN-1:0] vec_idx;
    logic            sample;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_cnt;
`ifdef SWEEP_ERR_LOG_EN
    logic            first_err_vld;
    logic [N_IN-1:0] first_err_vec;
    logic            first_err_obs;
`endif

    modport master (
        input  start, abort, dut_out,
        output dut_in, vec_idx, sample, busy, done, pass, err_cnt
`ifdef SWEEP_ERR_LOG_EN
        , output first_err_vld, first_err_vec, first_err_obs
`endif
    );

    modport slave (
        output start, abort, dut_out,
        input  dut_in, vec_idx, sample, busy, done, pass, err_cnt
`ifdef SWEEP_ERR_LOG_EN
        , input first_err_vld, first_err_vec, first_err_obs
`endif
    );
endinterface

// File: rtl/or3_sweep_ctrl.sv
// Sweeps every input vector of an N_IN-input OR gate, samples its output and counts mismatches.
// Define SWEEP_ERR_LOG_EN to also capture the vector and observed output of the first mismatch.
module or3_sweep_ctrl #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 5,
    parameter int GAP_CYCLES    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    or3_sweep_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_GAP,
        S_DONE
    } state_t;

    // One counter serves both SETTLE and GAP; it is cleared on entry to either.
    localparam int CNT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]   GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [N_IN:0]   ERR_MAX     = (N_IN + 1)'(2 ** N_IN);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [N_IN-1:0] dut_in_q;
    logic [N_IN-1:0] vec_idx_q;
    logic [N_IN:0]   err_cnt_q;
    logic            sample;
    logic            busy;
    logic            done;
    logic            last_vec;
    logic            mismatch;

    assign last_vec = (vec_idx_q == LAST_VEC);
    assign mismatch = (bus.dut_out !== (|dut_in_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_DRIVE;
            end
            S_DRIVE: begin
                busy       = 1'b1;
                state_next = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == SETTLE_LAST) state_next = S_CHECK;
            end
            S_CHECK: begin
                busy   = 1'b1;
                sample = 1'b1;
                if (last_vec) begin
                    state_next = S_DONE;
                end else if (GAP_CYCLES == 0) begin
                    state_next = S_DRIVE;
                end else begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                busy = 1'b1;
                if (cnt == GAP_LAST) state_next = S_DRIVE;
            end
            S_DONE: begin
                done = 1'b1;
                if (bus.start) state_next = S_DRIVE;
            end
            default: state_next = S_IDLE;
        endcase
        // abort outranks everything, including a simultaneous start
        if (bus.abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            dut_in_q      <= '0;
            vec_idx_q     <= '0;
            err_cnt_q     <= '0;
`ifdef SWEEP_ERR_LOG_EN
            bus.first_err_vld <= 1'b0;
            bus.first_err_vec <= '0;
            bus.first_err_obs <= 1'b0;
`endif
        end else if (bus.abort) begin
            cnt      <= '0;
            dut_in_q <= '0;
`ifdef SWEEP_ERR_LOG_EN
            bus.first_err_vld <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        vec_idx_q <= '0;
                        err_cnt_q <= '0;
`ifdef SWEEP_ERR_LOG_EN
                        bus.first_err_vld <= 1'b0;
`endif
                    end
                end
                S_DRIVE: begin
                    dut_in_q <= vec_idx_q;
                    cnt      <= '0;
                end
                S_SETTLE, S_GAP: begin
                    cnt <= cnt + 1'b1;
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (mismatch && (err_cnt_q != ERR_MAX)) err_cnt_q <= err_cnt_q + 1'b1;
                    if (!last_vec) vec_idx_q <= vec_idx_q + 1'b1;
`ifdef SWEEP_ERR_LOG_EN
                    if (mismatch && !bus.first_err_vld) begin
                        bus.first_err_vld <= 1'b1;
                        bus.first_err_vec <= dut_in_q;
                        bus.first_err_obs <= bus.dut_out;
                    end
`endif
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign bus.dut_in  = dut_in_q;
    assign bus.vec_idx = vec_idx_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.sample  = sample;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.pass    = done && (err_cnt_q == '0);

endmodule

// File: tb/tb_or3_sweep_ctrl.sv
// Bench for or3_sweep_ctrl: two instances (slow and fast timing) driven by a truth-table gate model.
// Expected timing and error counts come from arithmetic over the sweep rules, not from the RTL.
module tb_or3_sweep_ctrl;

    localparam int TIMEOUT = 1000;

    typedef struct {
        string      name;
        logic [7:0] tt;
        int         exp_err;
        int         exp_first;
        logic       exp_obs;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start_drv;
    logic       abort_drv;
    logic       dsel;
    logic [7:0] gate_tt;
    int         check_cnt;
    int         pass_cnt;
    vec_t       vecs[$];

    or3_sweep_ctrl_if #(.N_IN(3)) bus_a ();
    or3_sweep_ctrl_if #(.N_IN(3)) bus_b ();

    or3_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(5), .GAP_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    or3_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1), .GAP_CYCLES(0)) dut_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Gate under test is a truth table so faults can be planted per vector.
    assign bus_a.dut_out = gate_tt[bus_a.dut_in];
    assign bus_b.dut_out = gate_tt[bus_b.dut_in];
    assign bus_a.start   = start_drv & ~dsel;
    assign bus_a.abort   = abort_drv & ~dsel;
    assign bus_b.start   = start_drv & dsel;
    assign bus_b.abort   = abort_drv & dsel;

    logic [2:0] obs_dut_in;
    logic [2:0] obs_vec_idx;
    logic [3:0] obs_err_cnt;
    logic       obs_sample;
    logic       obs_busy;
    logic       obs_done;
    logic       obs_pass;
    assign obs_dut_in  = dsel ? bus_b.dut_in  : bus_a.dut_in;
    assign obs_vec_idx = dsel ? bus_b.vec_idx : bus_a.vec_idx;
    assign obs_err_cnt = dsel ? bus_b.err_cnt : bus_a.err_cnt;
    assign obs_sample  = dsel ? bus_b.sample  : bus_a.sample;
    assign obs_busy    = dsel ? bus_b.busy    : bus_a.busy;
    assign obs_done    = dsel ? bus_b.done    : bus_a.done;
    assign obs_pass    = dsel ? bus_b.pass    : bus_a.pass;
`ifdef SWEEP_ERR_LOG_EN
    logic       obs_fe_vld;
    logic [2:0] obs_fe_vec;
    logic       obs_fe_obs;
    assign obs_fe_vld = dsel ? bus_b.first_err_vld : bus_a.first_err_vld;
    assign obs_fe_vec = dsel ? bus_b.first_err_vec : bus_a.first_err_vec;
    assign obs_fe_obs = dsel ? bus_b.first_err_obs : bus_a.first_err_obs;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    function automatic int ref_err_count(input logic [7:0] tt);
        int n = 0;
        for (int v = 0; v < 8; v++) if (tt[v] != (v != 0)) n++;
        return n;
    endfunction

    function automatic int ref_first_err(input logic [7:0] tt);
        for (int v = 0; v < 8; v++) if (tt[v] != (v != 0)) return v;
        return -1;
    endfunction

    function automatic vec_t make_vec(input string name, input logic [7:0] tt, input int err,
                                      input int first, input logic obs);
        vec_t v;
        v.name      = name;
        v.tt        = tt;
        v.exp_err   = err;
        v.exp_first = first;
        v.exp_obs   = obs;
        return v;
    endfunction

    // One full sweep; sample k is due at lead + k*period clocks after the start pulse.
    task automatic applyStimulus(input vec_t v, input bit noise);
        int  c;
        int  k;
        bit  fin;
        int  lead;
        int  per;
        lead    = dsel ? 3 : 7;
        per     = dsel ? 3 : 17;
        gate_tt = v.tt;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        c   = 1;
        k   = 0;
        fin = 1'b0;
        checkOutput({v.name, "/busy_on_start"}, obs_busy, 1'b1);
        while (!fin && c < TIMEOUT) begin
            if (noise && obs_busy && $urandom_range(0, 5) == 0) start_drv = 1'b1;
            tick();
            c++;
            start_drv = 1'b0;
            if (obs_sample) begin
                if (k < 8) begin
                    checkOutput({v.name, "/sample_cycle"}, c, lead + k * per);
                    checkOutput({v.name, "/sample_dut_in"}, obs_dut_in, k);
                    checkOutput({v.name, "/sample_vec_idx"}, obs_vec_idx, k);
                end
                k++;
            end
            if (obs_done) fin = 1'b1;
        end
        checkOutput({v.name, "/done_seen"}, fin, 1'b1);
        checkOutput({v.name, "/done_cycle"}, c, lead + 7 * per + 1);
        checkOutput({v.name, "/sample_count"}, k, 8);
        checkOutput({v.name, "/err_cnt"}, obs_err_cnt, v.exp_err);
        checkOutput({v.name, "/pass"}, obs_pass, (v.exp_err == 0));
        checkOutput({v.name, "/busy_at_done"}, obs_busy, 1'b0);
        checkOutput({v.name, "/dut_in_hold"}, obs_dut_in, 3'd7);
`ifdef SWEEP_ERR_LOG_EN
        checkOutput({v.name, "/first_err_vld"}, obs_fe_vld, (v.exp_first >= 0));
        if (v.exp_first >= 0) begin
            checkOutput({v.name, "/first_err_vec"}, obs_fe_vec, v.exp_first);
            checkOutput({v.name, "/first_err_obs"}, obs_fe_obs, v.exp_obs);
        end
`endif
    endtask

    initial begin
        vec_t rv;
        bit   found;
        int   fe;
        check_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        start_drv = 1'b0;
        abort_drv = 1'b0;
        dsel      = 1'b0;
        gate_tt   = 8'hFE;

        vecs.push_back(make_vec("or_ok",     8'hFE, 0, -1, 1'b0));
        vecs.push_back(make_vec("stuck0",    8'h00, 7,  1, 1'b0));
        vecs.push_back(make_vec("c_ignored", 8'hEE, 1,  4, 1'b0));
        vecs.push_back(make_vec("stuck1",    8'hFF, 1,  0, 1'b1));
        vecs.push_back(make_vec("inverted",  8'h01, 8,  0, 1'b1));
        vecs.push_back(make_vec("vec7_bad",  8'h7E, 1,  7, 1'b0));

        #2;
        checkOutput("reset/dut_in",  bus_a.dut_in,  3'd0);
        checkOutput("reset/vec_idx", bus_a.vec_idx, 3'd0);
        checkOutput("reset/busy",    bus_a.busy,    1'b0);
        checkOutput("reset/done",    bus_a.done,    1'b0);
        checkOutput("reset/pass",    bus_a.pass,    1'b0);
        checkOutput("reset/sample",  bus_a.sample,  1'b0);
        checkOutput("reset/err_cnt", bus_a.err_cnt, 4'd0);
        checkOutput("reset/fast_busy", bus_b.busy,  1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle/busy", bus_a.busy, 1'b0);

        foreach (vecs[i]) applyStimulus(vecs[i], 1'b0);

        // Abort while vector 4 is settling; errors from vectors 1..3 must survive.
        $display("[TB] abort during settle of vector 4");
        gate_tt   = 8'h00;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        found = 1'b0;
        for (int i = 0; i < TIMEOUT && !found; i++) begin
            tick();
            if (obs_dut_in == 3'd4 && obs_busy) found = 1'b1;
        end
        checkOutput("abort/reached_vec4", found, 1'b1);
        tick();
        abort_drv = 1'b1;
        tick();
        abort_drv = 1'b0;
        checkOutput("abort/busy",    obs_busy,    1'b0);
        checkOutput("abort/done",    obs_done,    1'b0);
        checkOutput("abort/dut_in",  obs_dut_in,  3'd0);
        checkOutput("abort/sample",  obs_sample,  1'b0);
        checkOutput("abort/err_cnt", obs_err_cnt, 4'd3);
`ifdef SWEEP_ERR_LOG_EN
        checkOutput("abort/first_err_vld", obs_fe_vld, 1'b0);
`endif
        tick();
        tick();
        checkOutput("abort/stays_idle", obs_busy, 1'b0);
        applyStimulus(make_vec("resweep", 8'hFE, 0, -1, 1'b0), 1'b0);

        // Asynchronous reset in the gap after vector 2.
        $display("[TB] reset during gap of vector 2");
        gate_tt   = 8'h00;
        start_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        found = 1'b0;
        for (int i = 0; i < TIMEOUT && !found; i++) begin
            tick();
            if (obs_sample && obs_dut_in == 3'd2) found = 1'b1;
        end
        checkOutput("rst/reached_vec2", found, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rst/dut_in",  obs_dut_in,  3'd0);
        checkOutput("rst/vec_idx", obs_vec_idx, 3'd0);
        checkOutput("rst/busy",    obs_busy,    1'b0);
        checkOutput("rst/done",    obs_done,    1'b0);
        checkOutput("rst/pass",    obs_pass,    1'b0);
        checkOutput("rst/sample",  obs_sample,  1'b0);
        checkOutput("rst/err_cnt", obs_err_cnt, 4'd0);
`ifdef SWEEP_ERR_LOG_EN
        checkOutput("rst/first_err_vld", obs_fe_vld, 1'b0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        start_drv = 1'b1;
        abort_drv = 1'b1;
        tick();
        start_drv = 1'b0;
        abort_drv = 1'b0;
        checkOutput("start_abort/busy", obs_busy, 1'b0);
        tick();
        checkOutput("start_abort/still_idle", obs_busy, 1'b0);

        // Fast instance: one clock settle, no gap.
        dsel = 1'b1;
        tick();
        applyStimulus(make_vec("fast_ok", 8'hFE, 0, -1, 1'b0), 1'b0);
        applyStimulus(make_vec("fast_c_ignored", 8'hEE, 1, 4, 1'b0), 1'b0);

        // Random gate faults, random start pulses while busy, alternating instances.
        for (int i = 0; i < 8; i++) begin
            dsel         = i[0];
            rv.name      = $sformatf("rand%0d", i);
            rv.tt        = 8'($urandom);
            rv.exp_err   = ref_err_count(rv.tt);
            fe           = ref_first_err(rv.tt);
            rv.exp_first = fe;
            rv.exp_obs   = (fe >= 0) ? rv.tt[fe[2:0]] : 1'b0;
            tick();
            applyStimulus(rv, 1'b1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
